// File: rtl/ltc_pkg.sv
// -----------------------------------------------------------------------------
// ltc_pkg
// Shared definitions for the LTC generator and reader. It holds the 80-bit
// word length, the forward-play sync word, the bit positions of the time
// fields inside the word, the frame-rate encoding, and the latched time
// record used by the reader.
// -----------------------------------------------------------------------------
package ltc_pkg;

   localparam int          FRAME_BITS = 80;
   localparam logic [15:0] SYNC_WORD  = 16'hBFFC;
   localparam int          SYNC_LSB   = 64;

   // LSB positions of each BCD field within the 80-bit word (bit 0 is sent first)
   localparam int FRM_U_LSB = 0;
   localparam int FRM_T_LSB = 8;
   localparam int DROP_BIT  = 10;
   localparam int SEC_U_LSB = 16;
   localparam int SEC_T_LSB = 24;
   localparam int MIN_U_LSB = 32;
   localparam int MIN_T_LSB = 40;
   localparam int HR_U_LSB  = 48;
   localparam int HR_T_LSB  = 56;

   typedef enum logic [1:0] {
      FPS_24   = 2'd0,
      FPS_25   = 2'd1,
      FPS_2997 = 2'd2,
      FPS_30   = 2'd3
   } ltc_rate_e;

   typedef struct packed {
      logic [5:0] hours;    // {tens[1:0], units[3:0]}
      logic [6:0] minutes;  // {tens[2:0], units[3:0]}
      logic [6:0] seconds;  // {tens[2:0], units[3:0]}
      logic [5:0] frames;   // {tens[1:0], units[3:0]}
      logic       drop;
   } ltc_time_t;

   function automatic logic is_sync(input logic [15:0] word);
      return word == SYNC_WORD;
   endfunction

endpackage

// File: rtl/ltc_biphase_rx.sv
// -----------------------------------------------------------------------------
// ltc_biphase_rx
// Biphase-mark bit recovery. Synchronizes the raw line, measures the time
// between transitions and classifies each interval against an adaptive
// threshold derived from the last full-bit (zero) period.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   ltc_i        raw asynchronous LTC line
//   bit_stb_o    one-cycle strobe: a bit was recovered this cycle
//   bit_val_o    value of the recovered bit (valid with bit_stb_o)
//   bit_err_o    one-cycle flag: glitch, illegal half-bit pair or timeout
// All three outputs are combinational so the caller can act on them at the
// same clock edge that updates the classifier state.
// -----------------------------------------------------------------------------
module ltc_biphase_rx #(
   parameter int CNT_W   = 16,
   parameter int BIT_NOM = 5000
) (
   input  logic clk,
   input  logic reset,
   input  logic ltc_i,
   output logic bit_stb_o,
   output logic bit_val_o,
   output logic bit_err_o
);

   localparam logic [CNT_W-1:0] PER_SEED = CNT_W'(BIT_NOM);

   logic             s1_q, s2_q, s3_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] per_q, per_d;
   logic             half_q, half_d;
   logic             to_fired_q, to_fired_d;

   logic             edge_det;
   logic [CNT_W-1:0] quarter, thr;
   logic             timeout;
   logic             stb, val, err;

   always_comb begin
      edge_det   = s2_q ^ s3_q;
      quarter    = per_q >> 2;
      thr        = per_q - quarter;
      // Compare one bit wider so 2*per cannot wrap
      timeout    = !edge_det && !to_fired_q && ({1'b0, cnt_q} >= {per_q, 1'b0});

      stb        = 1'b0;
      val        = 1'b0;
      err        = 1'b0;
      half_d     = half_q;
      per_d      = per_q;
      to_fired_d = to_fired_q;

      if (edge_det)
         cnt_d = CNT_W'(1);
      else if (cnt_q != {CNT_W{1'b1}})
         cnt_d = cnt_q + CNT_W'(1);
      else
         cnt_d = cnt_q;

      if (edge_det) begin
         to_fired_d = 1'b0;
         if (cnt_q < quarter) begin
            err = 1'b1;
         end else if (cnt_q >= thr) begin
            if (half_q) begin
               err = 1'b1;             // long interval after a lone half-bit
            end else begin
               stb   = 1'b1;
               val   = 1'b0;
               per_d = cnt_q;          // track the actual bit rate
            end
         end else if (!half_q) begin
            half_d = 1'b1;
         end else begin
            stb    = 1'b1;
            val    = 1'b1;
            half_d = 1'b0;
         end
      end else if (timeout) begin
         err        = 1'b1;
         to_fired_d = 1'b1;
      end

      if (err) begin
         half_d = 1'b0;
         per_d  = PER_SEED;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
         cnt_q      <= '0;
         per_q      <= PER_SEED;
         half_q     <= 1'b0;
         to_fired_q <= 1'b0;
      end else begin
         s1_q       <= ltc_i;
         s2_q       <= s1_q;
         s3_q       <= s2_q;
         cnt_q      <= cnt_d;
         per_q      <= per_d;
         half_q     <= half_d;
         to_fired_q <= to_fired_d;
      end
   end

   assign bit_stb_o = stb;
   assign bit_val_o = val;
   assign bit_err_o = err;

endmodule

// File: rtl/ltc_decoder.sv
// -----------------------------------------------------------------------------
// ltc_decoder
// SMPTE 12M LTC reader. Recovers bits from the biphase-mark line, frames
// 80-bit words on the sync word and latches the BCD time fields.
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   ltc_in        raw asynchronous LTC line
//   hours_bcd     {tens[1:0], units[3:0]}
//   minutes_bcd   {tens[2:0], units[3:0]}
//   seconds_bcd   {tens[2:0], units[3:0]}
//   frames_bcd    {tens[1:0], units[3:0]}
//   drop_frame    drop-frame flag of the last latched word
//   frame_valid   one-cycle pulse when a new word is latched
//   locked        last two syncs were exactly 80 bits apart
//   bit_err       one-cycle pulse on any line error
// -----------------------------------------------------------------------------
module ltc_decoder
   import ltc_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int BIT_NOM = 5000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ltc_in,
   output logic [5:0] hours_bcd,
   output logic [6:0] minutes_bcd,
   output logic [6:0] seconds_bcd,
   output logic [5:0] frames_bcd,
   output logic       drop_frame,
   output logic       frame_valid,
   output logic       locked,
   output logic       bit_err
);

   localparam logic [6:0] BITCNT_MAX = 7'd127;
   localparam logic [6:0] BITCNT_FRM = 7'(FRAME_BITS);

   logic                  rx_stb, rx_val, rx_err;
   logic [FRAME_BITS-1:0] sr_q, sr_d;
   logic [6:0]            bitcnt_q, bitcnt_d;
   logic                  chk_q;       // a bit was shifted in last cycle
   ltc_time_t             time_q, time_d;
   logic                  fv_q, fv_d;
   logic                  locked_q, locked_d;
   logic                  err_q;
   logic                  sync_hit;

   ltc_biphase_rx #(
      .CNT_W   (CNT_W),
      .BIT_NOM (BIT_NOM)
   ) u_rx (
      .clk       (clk),
      .reset     (reset),
      .ltc_i     (ltc_in),
      .bit_stb_o (rx_stb),
      .bit_val_o (rx_val),
      .bit_err_o (rx_err)
   );

   always_comb begin
      sr_d     = sr_q;
      bitcnt_d = bitcnt_q;
      locked_d = locked_q;
      time_d   = time_q;
      fv_d     = 1'b0;
      // Only look for the sync word right after a shift so a word is seen once
      sync_hit = chk_q && is_sync(sr_q[FRAME_BITS-1:SYNC_LSB]);

      if (rx_stb) begin
         sr_d = {rx_val, sr_q[FRAME_BITS-1:1]};
         if (bitcnt_q != BITCNT_MAX)
            bitcnt_d = bitcnt_q + 7'd1;
      end

      if (sync_hit) begin
         time_d.frames  = {sr_q[FRM_T_LSB +: 2], sr_q[FRM_U_LSB +: 4]};
         time_d.drop    = sr_q[DROP_BIT];
         time_d.seconds = {sr_q[SEC_T_LSB +: 3], sr_q[SEC_U_LSB +: 4]};
         time_d.minutes = {sr_q[MIN_T_LSB +: 3], sr_q[MIN_U_LSB +: 4]};
         time_d.hours   = {sr_q[HR_T_LSB +: 2],  sr_q[HR_U_LSB +: 4]};
         fv_d           = 1'b1;
         locked_d       = (bitcnt_q == BITCNT_FRM);
         bitcnt_d       = rx_stb ? 7'd1 : 7'd0;
      end

      if (bitcnt_q > BITCNT_FRM)
         locked_d = 1'b0;

      if (rx_err) begin
         bitcnt_d = '0;
         locked_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q     <= '0;
         bitcnt_q <= '0;
         chk_q    <= 1'b0;
         time_q   <= '0;
         fv_q     <= 1'b0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         sr_q     <= sr_d;
         bitcnt_q <= bitcnt_d;
         chk_q    <= rx_stb;
         time_q   <= time_d;
         fv_q     <= fv_d;
         locked_q <= locked_d;
         err_q    <= rx_err;
      end
   end

   assign hours_bcd   = time_q.hours;
   assign minutes_bcd = time_q.minutes;
   assign seconds_bcd = time_q.seconds;
   assign frames_bcd  = time_q.frames;
   assign drop_frame  = time_q.drop;
   assign frame_valid = fv_q;
   assign locked      = locked_q;
   assign bit_err     = err_q;

endmodule

// File: tb/tb_ltc_decoder.sv
`timescale 1ns/1ps
// Bench for ltc_decoder. The bit period is shortened to 64 cycles so that a
// full run stays small; the other rates are scaled from it (24 fps -> 67,
// 30 fps -> 53, 29.97 fps -> 54, rounded up to stay distinct from 30 fps).
module tb_ltc_decoder;

   localparam int NOM = 64;

   logic       clk    = 1'b0;
   logic       reset  = 1'b1;
   logic       ltc_in = 1'b0;
   logic [5:0] hours_bcd;
   logic [6:0] minutes_bcd;
   logic [6:0] seconds_bcd;
   logic [5:0] frames_bcd;
   logic       drop_frame;
   logic       frame_valid;
   logic       locked;
   logic       bit_err;

   ltc_decoder #(.CNT_W(16), .BIT_NOM(NOM)) dut (
      .clk         (clk),
      .reset       (reset),
      .ltc_in      (ltc_in),
      .hours_bcd   (hours_bcd),
      .minutes_bcd (minutes_bcd),
      .seconds_bcd (seconds_bcd),
      .frames_bcd  (frames_bcd),
      .drop_frame  (drop_frame),
      .frame_valid (frame_valid),
      .locked      (locked),
      .bit_err     (bit_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] h;
      logic [6:0] m;
      logic [6:0] s;
      logic [5:0] f;
      logic       d;
      logic       lk;
      int         lat;
   } obs_t;

   typedef struct {
      int         per;
      logic [7:0] h;
      logic [7:0] m;
      logic [7:0] s;
      logic [7:0] f;
      logic       d;
      logic       lk;
   } vec_t;

   obs_t obs_q[$];
   vec_t vt[5];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   last_tog = 0;
   int   err_seen = 0;
   int   lock_drops = 0;
   logic lk_prev = 1'b0;

   always @(posedge clk) cyc++;

   // Monitor: one record and one line per latched word
   always @(negedge clk) begin
      obs_t o;
      if (frame_valid) begin
         o.h   = hours_bcd;
         o.m   = minutes_bcd;
         o.s   = seconds_bcd;
         o.f   = frames_bcd;
         o.d   = drop_frame;
         o.lk  = locked;
         o.lat = cyc - last_tog;
         obs_q.push_back(o);
         $display("frame %h:%h:%h:%h drop=%0b locked=%0b latency=%0d",
                  o.h, o.m, o.s, o.f, o.d, o.lk, o.lat);
      end
      if (bit_err) err_seen++;
      if (lk_prev && !locked) lock_drops++;
      lk_prev = locked;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic wt(input int n);
      repeat (n) @(negedge clk);
   endtask

   // A toggle at a falling edge is sampled by the next rising edge
   task automatic tog();
      ltc_in   = ~ltc_in;
      last_tog = cyc + 1;
   endtask

   // The start transition of each bit is the end transition of the previous one
   task automatic send_bit(input logic b, input int per);
      int h1;
      h1 = per / 2;
      wt(h1);
      if (b) tog();
      wt(per - h1);
      tog();
   endtask

   function automatic logic [79:0] mk_frame(input vec_t v);
      logic [79:0] w;
      w        = '0;
      w[3:0]   = v.f[3:0];
      w[9:8]   = v.f[5:4];
      w[10]    = v.d;
      w[19:16] = v.s[3:0];
      w[26:24] = v.s[6:4];
      w[35:32] = v.m[3:0];
      w[42:40] = v.m[6:4];
      w[51:48] = v.h[3:0];
      w[57:56] = v.h[5:4];
      w[79:64] = 16'hBFFC;
      return w;
   endfunction

   task automatic send_frame(input vec_t v);
      logic [79:0] w;
      w = mk_frame(v);
      for (int i = 0; i < 80; i++) send_bit(w[i], v.per);
   endtask

   task automatic check_obs(input string tag, input int idx, input vec_t v);
      if (idx < obs_q.size()) begin
         chk({tag, "_hours"},   32'(obs_q[idx].h),  32'(v.h[5:0]));
         chk({tag, "_minutes"}, 32'(obs_q[idx].m),  32'(v.m[6:0]));
         chk({tag, "_seconds"}, 32'(obs_q[idx].s),  32'(v.s[6:0]));
         chk({tag, "_frames"},  32'(obs_q[idx].f),  32'(v.f[5:0]));
         chk({tag, "_drop"},    32'(obs_q[idx].d),  32'(v.d));
         chk({tag, "_locked"},  32'(obs_q[idx].lk), 32'(v.lk));
         chk({tag, "_latency"}, 32'(obs_q[idx].lat), 32'd3);
      end
   endtask

   initial begin
      vec_t g1, g2, r1, r2;

      vt[0] = '{per: 64, h: 8'h12, m: 8'h34, s: 8'h56, f: 8'h12, d: 1'b0, lk: 1'b0};
      vt[1] = '{per: 64, h: 8'h12, m: 8'h34, s: 8'h56, f: 8'h13, d: 1'b0, lk: 1'b1};
      vt[2] = '{per: 67, h: 8'h01, m: 8'h02, s: 8'h03, f: 8'h04, d: 1'b1, lk: 1'b1};
      vt[3] = '{per: 53, h: 8'h23, m: 8'h59, s: 8'h59, f: 8'h29, d: 1'b1, lk: 1'b1};
      vt[4] = '{per: 54, h: 8'h10, m: 8'h20, s: 8'h30, f: 8'h02, d: 1'b1, lk: 1'b1};
      g1    = '{per: 64, h: 8'h12, m: 8'h00, s: 8'h00, f: 8'h00, d: 1'b0, lk: 1'b0};
      g2    = '{per: 64, h: 8'h12, m: 8'h00, s: 8'h00, f: 8'h01, d: 1'b0, lk: 1'b1};
      r1    = '{per: 64, h: 8'h07, m: 8'h45, s: 8'h09, f: 8'h10, d: 1'b0, lk: 1'b0};
      r2    = '{per: 64, h: 8'h07, m: 8'h45, s: 8'h09, f: 8'h11, d: 1'b0, lk: 1'b1};

      // ---- reset ----
      reset = 1'b1;
      wt(5);
      chk("rst_hours",   32'(hours_bcd),   32'd0);
      chk("rst_minutes", 32'(minutes_bcd), 32'd0);
      chk("rst_seconds", 32'(seconds_bcd), 32'd0);
      chk("rst_frames",  32'(frames_bcd),  32'd0);
      chk("rst_drop",    32'(drop_frame),  32'd0);
      chk("rst_valid",   32'(frame_valid), 32'd0);
      chk("rst_locked",  32'(locked),      32'd0);
      chk("rst_err",     32'(bit_err),     32'd0);
      reset = 1'b0;

      // ---- single frame, second frame, rate sweep ----
      wt(NOM);
      tog();
      for (int i = 0; i < 4; i++) send_bit(1'b0, NOM);
      for (int i = 0; i < 5; i++) send_frame(vt[i]);
      send_bit(1'b0, vt[4].per);
      chk("sweep_count", 32'(obs_q.size()), 32'd5);
      for (int i = 0; i < 5; i++) check_obs($sformatf("sweep%0d", i), i, vt[i]);
      chk("sweep_err",        32'(err_seen),   32'd0);
      chk("sweep_lock_drops", 32'(lock_drops), 32'd0);
      chk("sweep_locked_now", 32'(locked),     32'd1);
      chk("sweep_drop_now",   32'(drop_frame), 32'd1);

      // ---- glitch inside a zero bit ----
      obs_q.delete();
      err_seen = 0;
      begin
         logic [79:0] w;
         w = mk_frame(g1);
         for (int i = 0; i < 4; i++) send_bit(w[i], NOM);
         wt(8); tog(); wt(3); tog(); wt(NOM - 11); tog();
         chk("glitch_err_seen", 32'(err_seen > 0), 32'd1);
         chk("glitch_locked",   32'(locked),       32'd0);
         for (int i = 5; i < 80; i++) send_bit(w[i], NOM);
      end
      send_frame(g2);
      send_bit(1'b0, NOM);
      chk("glitch_count", 32'(obs_q.size()), 32'd2);
      check_obs("glitch_first", 0, g1);
      check_obs("glitch_next",  1, g2);

      // ---- timeout: line static well beyond 2*per ----
      obs_q.delete();
      err_seen = 0;
      wt(200);
      chk("timeout_err_count", 32'(err_seen),      32'd1);
      chk("timeout_locked",    32'(locked),        32'd0);
      chk("timeout_hours",     32'(hours_bcd),     32'(g2.h[5:0]));
      chk("timeout_frames",    32'(frames_bcd),    32'(g2.f[5:0]));
      chk("timeout_count",     32'(obs_q.size()),  32'd0);

      // ---- reset in the middle of bit 40 ----
      begin
         logic [79:0] w;
         w = mk_frame(r1);
         for (int i = 0; i < 40; i++) send_bit(w[i], NOM);
         wt(4);
         reset = 1'b1;
         wt(5);
         chk("midrst_hours",   32'(hours_bcd),   32'd0);
         chk("midrst_minutes", 32'(minutes_bcd), 32'd0);
         chk("midrst_seconds", 32'(seconds_bcd), 32'd0);
         chk("midrst_frames",  32'(frames_bcd),  32'd0);
         chk("midrst_locked",  32'(locked),      32'd0);
         reset = 1'b0;
         obs_q.delete();
         wt(NOM / 2 - 9);
         if (w[40]) tog();
         wt(NOM - NOM / 2);
         tog();
         for (int i = 41; i < 80; i++) send_bit(w[i], NOM);
      end
      send_frame(r2);
      send_bit(1'b0, NOM);
      chk("midrst_count", 32'(obs_q.size()), 32'd2);
      if (obs_q.size() > 0) begin
         // Only bits 40..79 were received after reset; the lower fields are zero
         chk("midrst_first_locked",  32'(obs_q[0].lk), 32'd0);
         chk("midrst_first_hours",   32'(obs_q[0].h),  32'h07);
         chk("midrst_first_minutes", 32'(obs_q[0].m),  32'h40);
         chk("midrst_first_seconds", 32'(obs_q[0].s),  32'h00);
      end
      check_obs("midrst_second", 1, r2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
